// File: rtl/radar_evt_pkg.sv
// Shared types for the sweep target-event generator: FSM states, event codes, queue entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package radar_evt_pkg;

  localparam int ADDR_W = 10;
  localparam int BEAR_W = 12;
  localparam int AMP_W  = 12;

  // Confirm FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OFF     = 3'd1,
    ST_ON_CHK  = 3'd2,
    ST_ON      = 3'd3,
    ST_OFF_CHK = 3'd4
  } state_e;

  // Event type codes
  localparam logic EVT_START = 1'b0;
  localparam logic EVT_END   = 1'b1;

  // Queue entry {type, addr, bear, f2, f1}
  localparam int EVT_W        = 25;
  localparam int EVT_F1_OFF   = 0;
  localparam int EVT_F2_OFF   = 1;
  localparam int EVT_BEAR_OFF = 2;
  localparam int EVT_ADDR_OFF = 14;
  localparam int EVT_TYPE_OFF = 24;

  typedef struct packed {
    logic              typ;
    logic [ADDR_W-1:0] addr;
    logic [BEAR_W-1:0] bear;
    logic              f2;
    logic              f1;
  } evt_t;

endpackage

// File: rtl/target_event_gen_if.sv
// Sample-in / event-out bundle of the target event generator.
// Latency: n/a (wires only).
// Backpressure: none; the event side is strobe-only, overflow is reported on ovf.
interface target_event_gen_if;
  import radar_evt_pkg::*;

  // Sweep and sample side
  logic              sweep_start;
  logic [BEAR_W-1:0] bear_in;
  logic              f1_in;
  logic              f2_in;
  logic              smp_vld;
  logic [AMP_W-1:0]  smp_amp;
  logic [AMP_W-1:0]  man_door;
  logic [AMP_W-1:0]  auto_door;
  logic              nv_mti_door;

  // Event side
  logic [ADDR_W-1:0] addr;
  logic [BEAR_W-1:0] bear;
  logic              f1;
  logic              f2;
  logic              swd_done;
  logic              target_start;
  logic              target_end;
  logic              ovf;

  modport master (
    output sweep_start, bear_in, f1_in, f2_in, smp_vld, smp_amp,
           man_door, auto_door, nv_mti_door,
    input  addr, bear, f1, f2, swd_done, target_start, target_end, ovf
  );

  modport slave (
    input  sweep_start, bear_in, f1_in, f2_in, smp_vld, smp_amp,
           man_door, auto_door, nv_mti_door,
    output addr, bear, f1, f2, swd_done, target_start, target_end, ovf
  );

endinterface

// File: rtl/evt_queue.sv
// Small synchronous FIFO for confirmed target events (DEPTH power of 2, >= 2).
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: push while full is refused unless a pop happens on the same edge.
module evt_queue
  import radar_evt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = EVT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_FULL);
  assign do_pop    = pop_i && !empty_o;
  // A pop on the same edge frees the slot the push needs.
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/target_event_gen.sv
// Confirms target leading/trailing edges along a sweep and emits tagged start/end strobes.
// Latency: confirming sample edge -> swd_done visible one cycle later (queue empty, gap expired).
// Backpressure: none upstream; events beyond the queue depth are dropped and flagged on sticky ovf.
module target_event_gen
  import radar_evt_pkg::*;
#(
  parameter int RANGE_BINS = 1024,
  parameter int MIN_HIT    = 3,
  parameter int MIN_MISS   = 2,
  parameter int EVQ_DEPTH  = 4,
  parameter int EVT_GAP    = 4    // 1..256
) (
  input logic               wrclk,
  input logic               reset,
  target_event_gen_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_BIN   = ADDR_W'(RANGE_BINS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [3:0]        MIN_HIT_C  = 4'(MIN_HIT);
  localparam logic [3:0]        MIN_MISS_C = 4'(MIN_MISS);
  localparam logic [7:0]        GAP_LOAD   = 8'(EVT_GAP - 1);

  // Confirm FSM and sweep context
  state_e            state_q, state_d, cur_st;
  logic [ADDR_W-1:0] rng_q, rng_d, cur_rng;
  logic [ADDR_W-1:0] st_q, st_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BEAR_W-1:0] bear_q, bear_d;
  logic              f1_q, f1_d;
  logic              f2_q, f2_d;
  logic              pend_q, pend_d;

  logic [AMP_W-1:0]  thr;
  logic              hit;

  // Event request from the FSM
  logic              ev_vld;
  logic              ev_type;
  logic [ADDR_W-1:0] ev_addr;

  // Queue side
  evt_t              push_evt;
  logic              push_vld;
  logic [EVT_W-1:0]  push_dat;
  logic [EVT_W-1:0]  pop_dat;
  logic              q_full;
  logic              q_empty;
  logic              pop;

  // Output registers
  logic [ADDR_W-1:0] addr_q;
  logic [BEAR_W-1:0] obear_q;
  logic              of1_q;
  logic              of2_q;
  logic              done_q;
  logic              tstart_q;
  logic              tend_q;
  logic              ovf_q;
  logic [7:0]        gap_q;

  assign thr = bus.nv_mti_door ? bus.auto_door : bus.man_door;
  assign hit = (bus.smp_amp >= thr);

  // FSM state register plus the sweep context it carries.
  always_ff @(posedge wrclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rng_q   <= '0;
      st_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      bear_q  <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rng_q   <= rng_d;
      st_q    <= st_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bear_q  <= bear_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: sweep restart first, then the sample (bin 0 if restarting), then end-of-sweep flush.
  always_comb begin
    state_d = state_q;
    rng_d   = rng_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    last_d  = last_q;
    bear_d  = bear_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    pend_d  = 1'b0;
    ev_vld  = 1'b0;
    ev_type = EVT_START;
    ev_addr = '0;
    cur_st  = state_q;
    cur_rng = rng_q;

    // END deferred from a last bin that also confirmed a START.
    if (pend_q) begin
      ev_vld  = 1'b1;
      ev_type = EVT_END;
      ev_addr = last_q;
    end

    if (bus.sweep_start) begin
      // Close an open target with the old sweep's tags before relatching them.
      if (state_q == ST_ON || state_q == ST_OFF_CHK) begin
        ev_vld  = 1'b1;
        ev_type = EVT_END;
        ev_addr = last_q;
      end
      bear_d  = bus.bear_in;
      f1_d    = bus.f1_in;
      f2_d    = bus.f2_in;
      cur_st  = ST_OFF;
      cur_rng = '0;
      state_d = ST_OFF;
      rng_d   = '0;
    end

    if (bus.smp_vld && cur_st != ST_IDLE) begin
      rng_d = cur_rng + ADDR_ONE;
      case (cur_st)
        ST_OFF: begin
          if (hit) begin
            state_d = ST_ON_CHK;
            cnt_d   = 4'd1;
            st_d    = cur_rng;
          end
        end
        ST_ON_CHK: begin
          if (!hit) begin
            state_d = ST_OFF;
          end else if (cnt_q + 4'd1 == MIN_HIT_C) begin
            ev_vld  = 1'b1;
            ev_type = EVT_START;
            ev_addr = st_q;
            state_d = ST_ON;
            last_d  = cur_rng;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_ON: begin
          if (hit) begin
            last_d = cur_rng;
          end else if (MIN_MISS_C == 4'd1) begin
            ev_vld  = 1'b1;
            ev_type = EVT_END;
            ev_addr = last_q;
            state_d = ST_OFF;
          end else begin
            state_d = ST_OFF_CHK;
            cnt_d   = 4'd1;
          end
        end
        ST_OFF_CHK: begin
          if (hit) begin
            state_d = ST_ON;
            last_d  = cur_rng;
          end else if (cnt_q + 4'd1 == MIN_MISS_C) begin
            ev_vld  = 1'b1;
            ev_type = EVT_END;
            ev_addr = last_q;
            state_d = ST_OFF;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase

      // Last bin closes any open target; an unconfirmed start is discarded.
      if (cur_rng == LAST_BIN) begin
        if (state_d == ST_ON || state_d == ST_OFF_CHK) begin
          if (ev_vld) begin
            pend_d = 1'b1;
          end else begin
            ev_vld  = 1'b1;
            ev_type = EVT_END;
            ev_addr = last_d;
          end
        end
        state_d = ST_IDLE;
      end
    end
  end

  // Outputs of the FSM: queue entry assembly and the pop decision.
  always_comb begin
    push_evt      = '0;
    push_evt.typ  = ev_type;
    push_evt.addr = ev_addr;
    push_evt.bear = bear_q;
    push_evt.f2   = f2_q;
    push_evt.f1   = f1_q;
    push_vld      = ev_vld;
    push_dat      = push_evt;
    pop           = !q_empty && (gap_q == '0);
  end

  evt_queue #(
    .DEPTH (EVQ_DEPTH),
    .W     (EVT_W)
  ) u_evt_queue (
    .clk_i      (wrclk),
    .rst_i      (reset),
    .push_i     (push_vld),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (pop_dat),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  // Event emission: capture the head on pop, strobe for one cycle, then hold off for the gap.
  always_ff @(posedge wrclk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      obear_q  <= '0;
      of1_q    <= 1'b0;
      of2_q    <= 1'b0;
      done_q   <= 1'b0;
      tstart_q <= 1'b0;
      tend_q   <= 1'b0;
      gap_q    <= '0;
    end else if (pop) begin
      addr_q   <= pop_dat[EVT_ADDR_OFF +: ADDR_W];
      obear_q  <= pop_dat[EVT_BEAR_OFF +: BEAR_W];
      of1_q    <= pop_dat[EVT_F1_OFF];
      of2_q    <= pop_dat[EVT_F2_OFF];
      done_q   <= 1'b1;
      tstart_q <= (pop_dat[EVT_TYPE_OFF] == EVT_START);
      tend_q   <= (pop_dat[EVT_TYPE_OFF] == EVT_END);
      gap_q    <= GAP_LOAD;
    end else begin
      done_q   <= 1'b0;
      tstart_q <= 1'b0;
      tend_q   <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 8'd1;
    end
  end

  // Sticky overflow: only a push that finds the queue full with no pop that edge is lost.
  always_ff @(posedge wrclk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (push_vld && q_full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.addr         = addr_q;
  assign bus.bear         = obear_q;
  assign bus.f1           = of1_q;
  assign bus.f2           = of2_q;
  assign bus.swd_done     = done_q;
  assign bus.target_start = tstart_q;
  assign bus.target_end   = tend_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_target_event_gen.sv
module tb_target_event_gen;
  import radar_evt_pkg::*;

  localparam int NBINS   = 1024;
  localparam int EVT_GAP = 8;

  logic wrclk = 1'b0;
  logic reset = 1'b1;

  target_event_gen_if tif();

  target_event_gen #(
    .RANGE_BINS (NBINS),
    .MIN_HIT    (3),
    .MIN_MISS   (2),
    .EVQ_DEPTH  (4),
    .EVT_GAP    (EVT_GAP)
  ) dut (
    .wrclk (wrclk),
    .reset (reset),
    .bus   (tif)
  );

  always #5 wrclk = ~wrclk;

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_cyc = -1;
  evt_t sb[$];
  logic [11:0] amp_tab [NBINS];
  logic        ovf_after [NBINS];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_evt(input logic typ, input int addr, input logic [11:0] bear,
                         input logic f1, input logic f2);
    evt_t e;
    e.typ  = typ;
    e.addr = 10'(addr);
    e.bear = bear;
    e.f1   = f1;
    e.f2   = f2;
    sb.push_back(e);
  endtask

  task automatic amp_clear();
    for (int i = 0; i < NBINS; i++) amp_tab[i] = 12'd0;
  endtask

  task automatic amp_run(input int lo, input int hi, input logic [11:0] val);
    for (int i = lo; i <= hi; i++) amp_tab[i] = val;
  endtask

  // Drives bins 0..nbins-1 back to back, sweep_start with bin 0; records ovf after each edge.
  task automatic drive_sweep(input int nbins, input logic [11:0] bear, input logic f1, input logic f2);
    for (int b = 0; b < nbins; b++) begin
      tif.sweep_start = (b == 0);
      tif.bear_in     = bear;
      tif.f1_in       = f1;
      tif.f2_in       = f2;
      tif.smp_vld     = 1'b1;
      tif.smp_amp     = amp_tab[b];
      @(posedge wrclk);
      #1;
      ovf_after[b] = tif.ovf;
    end
    tif.sweep_start = 1'b0;
    tif.smp_vld     = 1'b0;
    tif.smp_amp     = 12'd0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge wrclk);
      #1;
      n++;
    end
    chk_eq({tag, "_drained"}, sb.size(), 0);
    repeat (EVT_GAP + 2) @(posedge wrclk);
    #1;
  endtask

  always @(posedge wrclk) cyc <= cyc + 1;

  // Scoreboard side: every strobe must match the oldest expected event.
  always @(negedge wrclk) begin : mon
    evt_t e;
    if (tif.swd_done) begin
      chk_eq("evt_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_eq("evt_addr", tif.addr, e.addr);
        chk_eq("evt_bear", tif.bear, e.bear);
        chk_eq("evt_f1f2", {tif.f1, tif.f2}, {e.f1, e.f2});
        chk_eq("evt_kind", {tif.target_start, tif.target_end},
               (e.typ == EVT_START) ? 2'b10 : 2'b01);
      end
      if (last_cyc >= 0) chk_eq("evt_gap", (cyc - last_cyc) >= EVT_GAP, 1);
      last_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tif.sweep_start = 1'b0;
    tif.bear_in     = 12'd0;
    tif.f1_in       = 1'b0;
    tif.f2_in       = 1'b0;
    tif.smp_vld     = 1'b0;
    tif.smp_amp     = 12'd0;
    tif.man_door    = 12'd100;
    tif.auto_door   = 12'd0;
    tif.nv_mti_door = 1'b0;
    amp_clear();

    // Reset state
    #20;
    chk_eq("rst_addr", tif.addr, 0);
    chk_eq("rst_bear", tif.bear, 0);
    chk_eq("rst_tags", {tif.f1, tif.f2}, 0);
    chk_eq("rst_strobes", {tif.swd_done, tif.target_start, tif.target_end}, 0);
    chk_eq("rst_ovf", tif.ovf, 0);
    #3 reset = 1'b0;
    @(posedge wrclk);
    #1;

    // 1: manual threshold, run on bins 10..19
    amp_clear();
    amp_run(10, 19, 12'd200);
    exp_evt(EVT_START, 10, 12'h101, 1'b1, 1'b0);
    exp_evt(EVT_END,   19, 12'h101, 1'b1, 1'b0);
    drive_sweep(NBINS, 12'h101, 1'b1, 1'b0);
    drain("t1");

    // 2: short runs never confirm; a one-bin hole does not split a target
    amp_clear();
    amp_run(5, 6, 12'd200);
    amp_run(30, 40, 12'd200);
    amp_tab[35] = 12'd0;
    amp_run(200, 201, 12'd200);
    amp_run(203, 204, 12'd200);
    exp_evt(EVT_START, 30, 12'h202, 1'b0, 1'b0);
    exp_evt(EVT_END,   40, 12'h202, 1'b0, 1'b0);
    drive_sweep(NBINS, 12'h202, 1'b0, 1'b0);
    drain("t2");

    // 3: auto threshold selected, then the same data against the manual threshold
    tif.auto_door   = 12'd50;
    tif.man_door    = 12'd4000;
    tif.nv_mti_door = 1'b1;
    amp_clear();
    amp_run(100, 110, 12'd60);
    exp_evt(EVT_START, 100, 12'h303, 1'b0, 1'b1);
    exp_evt(EVT_END,   110, 12'h303, 1'b0, 1'b1);
    drive_sweep(NBINS, 12'h303, 1'b0, 1'b1);
    drain("t3a");
    tif.nv_mti_door = 1'b0;
    drive_sweep(NBINS, 12'h304, 1'b0, 1'b1);
    drain("t3b");

    // 4a: target running into the last bin
    tif.man_door = 12'd100;
    amp_clear();
    amp_run(1000, 1023, 12'd200);
    exp_evt(EVT_START, 1000, 12'h3ff, 1'b1, 1'b0);
    exp_evt(EVT_END,   1023, 12'h3ff, 1'b1, 1'b0);
    drive_sweep(NBINS, 12'h3ff, 1'b1, 1'b0);
    drain("t4a");

    // 4b: sweep_start while a target is open, new sweep hits at bin 0
    amp_clear();
    amp_run(390, 420, 12'd200);
    exp_evt(EVT_START, 390, 12'h123, 1'b1, 1'b1);
    exp_evt(EVT_END,   400, 12'h123, 1'b1, 1'b1);
    drive_sweep(401, 12'h123, 1'b1, 1'b1);
    amp_clear();
    amp_run(0, 2, 12'd200);
    exp_evt(EVT_START, 0, 12'h124, 1'b0, 1'b0);
    exp_evt(EVT_END,   2, 12'h124, 1'b0, 1'b0);
    drive_sweep(NBINS, 12'h124, 1'b0, 1'b0);
    drain("t4b");

    // 4c: start confirmed on the last bin itself
    amp_clear();
    amp_run(1021, 1023, 12'd200);
    exp_evt(EVT_START, 1021, 12'h0aa, 1'b0, 1'b1);
    exp_evt(EVT_END,   1023, 12'h0aa, 1'b0, 1'b1);
    drive_sweep(NBINS, 12'h0aa, 1'b0, 1'b1);
    drain("t4c");

    // 5: burst of short targets against a 4-deep queue
    chk_eq("t5_ovf_pre", tif.ovf, 0);
    amp_clear();
    amp_run(100, 102, 12'd200);
    amp_run(105, 107, 12'd200);
    amp_run(110, 112, 12'd200);
    amp_run(117, 119, 12'd200);
    amp_run(130, 132, 12'd200);
    amp_run(135, 137, 12'd200);
    exp_evt(EVT_START, 100, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_END,   102, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_START, 105, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_END,   107, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_START, 110, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_END,   112, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_START, 117, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_START, 130, 12'h055, 1'b1, 1'b0);
    exp_evt(EVT_START, 135, 12'h055, 1'b1, 1'b0);
    drive_sweep(NBINS, 12'h055, 1'b1, 1'b0);
    chk_eq("t5_ovf_b118", ovf_after[118], 0);
    chk_eq("t5_ovf_full_push_pop", ovf_after[119], 0);
    chk_eq("t5_ovf_b120", ovf_after[120], 0);
    chk_eq("t5_ovf_drop", ovf_after[121], 1);
    drain("t5");
    chk_eq("t5_ovf_sticky", tif.ovf, 1);

    // 6: reset with three events still queued
    amp_clear();
    amp_run(100, 102, 12'd200);
    amp_run(105, 107, 12'd200);
    amp_run(110, 112, 12'd200);
    exp_evt(EVT_START, 100, 12'h066, 1'b0, 1'b1);
    exp_evt(EVT_END,   102, 12'h066, 1'b0, 1'b1);
    drive_sweep(113, 12'h066, 1'b0, 1'b1);
    chk_eq("t6_pre_addr", tif.addr, 102);
    #2 reset = 1'b1;
    #1;
    chk_eq("t6_rst_addr", tif.addr, 0);
    chk_eq("t6_rst_bear", tif.bear, 0);
    chk_eq("t6_rst_tags", {tif.f1, tif.f2}, 0);
    chk_eq("t6_rst_ovf", tif.ovf, 0);
    repeat (2) @(posedge wrclk);
    #3 reset = 1'b0;
    repeat (60) @(posedge wrclk);
    #1;
    chk_eq("t6_no_events", sb.size(), 0);
    chk_eq("t6_ovf_after", tif.ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
